// File: rtl/ff_share_sched_pkg.sv
// Shared types, default dimensions and the signed-magnitude compare used by ff_share_sched.
package ff_share_sched_pkg;

  localparam int N = 16;
  localparam int F = 8;
  localparam int NSTATES = 3;
  localparam int NACTIONS = 4;

  typedef enum logic [1:0] {IDLE, RUN, RESP} sched_state_e;

  typedef logic [N-1:0] word_t;

  // Signed-magnitude a > b; both zero encodings compare equal.
  function automatic logic sm_gt(input word_t a, input word_t b);
    logic a_neg;
    logic b_neg;
    a_neg = a[N-1] && (a[N-2:0] != '0);
    b_neg = b[N-1] && (b[N-2:0] != '0);
    if (a_neg != b_neg) return b_neg;
    if (!a_neg) return a[N-2:0] > b[N-2:0];
    return a[N-2:0] < b[N-2:0];
  endfunction

endpackage

// File: rtl/ff_share_sched_if.sv
// Requester/consumer bundle of ff_share_sched; rsp_action exists only with FF_SCHED_ARGMAX_EN.
interface ff_share_sched_if #(
  parameter int NREQ     = 4,
  parameter int NSTATES  = 3,
  parameter int NACTIONS = 4,
  parameter int N        = 16
);
  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(NACTIONS);

  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0][NSTATES-1:0]   req_x;
  logic [NREQ-1:0]                req_ready;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [IDW-1:0]                 rsp_id;
  logic [NACTIONS-1:0][N-1:0]     rsp_q;
`ifdef FF_SCHED_ARGMAX_EN
  logic [AW-1:0]                  rsp_action;
`endif

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q
`ifdef FF_SCHED_ARGMAX_EN
    , input rsp_action
`endif
  );

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q
`ifdef FF_SCHED_ARGMAX_EN
    , output rsp_action
`endif
  );

endinterface

// File: rtl/ff_share_sched_argmax.sv
// ff_argmax: combinational argmax over NACTIONS signed-magnitude words, ties resolve to lowest index.
module ff_argmax
  import ff_share_sched_pkg::*;
#(
  parameter int NACTIONS = ff_share_sched_pkg::NACTIONS
) (
  input  word_t [NACTIONS-1:0]       q,
  output logic [$clog2(NACTIONS)-1:0] idx
);

  localparam int AW = $clog2(NACTIONS);
  localparam int P  = 1 << AW;

  // Binary tree, leaves padded to a power of two; the left child always holds lower indices.
  function automatic logic [AW-1:0] tree_max(input word_t [NACTIONS-1:0] v);
    word_t         val [1:2*P-1];
    logic [AW-1:0] id  [1:2*P-1];
    logic          ok  [1:2*P-1];
    for (int k = 0; k < P; k++) begin
      ok[P+k]  = (k < NACTIONS);
      id[P+k]  = AW'(k);
      val[P+k] = '0;
      if (k < NACTIONS) val[P+k] = v[k];
    end
    for (int n = P - 1; n >= 1; n--) begin
      if (ok[2*n+1] && (!ok[2*n] || sm_gt(val[2*n+1], val[2*n]))) begin
        val[n] = val[2*n+1];
        id[n]  = id[2*n+1];
      end else begin
        val[n] = val[2*n];
        id[n]  = id[2*n];
      end
      ok[n] = ok[2*n] || ok[2*n+1];
    end
    return id[1];
  endfunction

  always_comb idx = tree_max(q);

endmodule

// File: rtl/ff_share_sched.sv
// Round-robin scheduler sharing one combinational ff instance among NREQ requesters, one job in flight.
// Optional argmax of the captured outputs is enabled by defining FF_SCHED_ARGMAX_EN.
module ff_share_sched
  import ff_share_sched_pkg::*;
#(
  parameter int N        = ff_share_sched_pkg::N,
  parameter int NSTATES  = ff_share_sched_pkg::NSTATES,
  parameter int NACTIONS = ff_share_sched_pkg::NACTIONS,
  parameter int NREQ     = 4,
  parameter int SETTLE   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ff_share_sched_if.slave            bus,
  output logic [NSTATES-1:0]         ff_x,
  input  logic [NACTIONS-1:0][N-1:0] ff_out
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(SETTLE + 1);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic           any_req;
  logic [CW-1:0]  cnt;

  // Lowest set bit of {valid, valid & (>= rr_ptr)} gives the next requester at or after rr_ptr.
  always_comb begin : rr_grant
    logic [NREQ-1:0]   mask;
    logic [2*NREQ-1:0] dbl;
    logic              found;
    int                gidx;
    mask  = '0;
    found = 1'b0;
    gidx  = 0;
    for (int i = 0; i < NREQ; i++) mask[i] = (IDW'(i) >= rr_ptr);
    dbl = {bus.req_valid, bus.req_valid & mask};
    for (int j = 0; j < 2 * NREQ; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        gidx  = j % NREQ;
      end
    end
    grant   = IDW'(gidx);
    any_req = |bus.req_valid;
  end

  assign bus.req_ready = (rst_n && state_q == IDLE && any_req) ? (NREQ'(1) << grant) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = RUN;
      RUN:     if (cnt == '0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef FF_SCHED_ARGMAX_EN
  logic [$clog2(NACTIONS)-1:0] amax;

  ff_argmax #(.NACTIONS(NACTIONS)) u_argmax (
    .q   (ff_out),
    .idx (amax)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      ff_x          <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_q     <= '0;
`ifdef FF_SCHED_ARGMAX_EN
      bus.rsp_action <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ff_x       <= bus.req_x[grant];
            bus.rsp_id <= grant;
            rr_ptr     <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
            cnt        <= CW'(SETTLE - 1);
          end
        end
        RUN: begin
          // ff_x stays put after capture so the shared ff sees no input change between jobs.
          if (cnt == '0) begin
            bus.rsp_q     <= ff_out;
            bus.rsp_valid <= 1'b1;
`ifdef FF_SCHED_ARGMAX_EN
            bus.rsp_action <= amax;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_share_sched.sv
// Directed + randomized bench for ff_share_sched; the ff is modelled as a salted function of ff_x.
module tb_ff_share_sched;
  import ff_share_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int NST  = 3;
  localparam int NACT = 4;
  localparam int NW   = 16;
  localparam int SET  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NST-1:0]            ff_x;
  logic [NACT-1:0][NW-1:0]   ff_out;

  ff_share_sched_if #(.NREQ(NREQ), .NSTATES(NST), .NACTIONS(NACT), .N(NW)) bus ();

  ff_share_sched #(.N(NW), .NSTATES(NST), .NACTIONS(NACT), .NREQ(NREQ), .SETTLE(SET)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .ff_x   (ff_x),
    .ff_out (ff_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rr = 0;
  int last_acc = 0;
  int last_bp = 0;
  logic [31:0]             salt = 32'h0;
  bit                      use_fixed = 1'b0;
  logic [NACT-1:0][NW-1:0] fixed_q = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NACT-1:0][NW-1:0] ffm(input logic [NST-1:0] x, input logic [31:0] s);
    logic [NACT-1:0][NW-1:0] r;
    for (int k = 0; k < NACT; k++)
      r[k] = s[15:0] ^ (16'(x) << (3 * k)) ^ 16'(k * 4369);
    return r;
  endfunction

  always_comb ff_out = use_fixed ? fixed_q : ffm(ff_x, salt);

  function automatic int model_grant(input logic [NREQ-1:0] vm);
    for (int k = 0; k < NREQ; k++)
      if (vm[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic int sm_val(input logic [NW-1:0] w);
    int m;
    m = int'(w[NW-2:0]);
    return w[NW-1] ? -m : m;
  endfunction

  function automatic int ref_argmax(input logic [NACT-1:0][NW-1:0] q);
    int best;
    best = 0;
    for (int k = 1; k < NACT; k++)
      if (sm_val(q[k]) > sm_val(q[best])) best = k;
    return best;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete job: grant, run, capture, optional backpressure, response handshake.
  task automatic run_job(input logic [NREQ-1:0] vm, input int bp, input bit keep,
                         input bit rnd_x, input bit pulse, input bit chk_gap);
    int g;
    logic [NST-1:0]          xg;
    logic [NACT-1:0][NW-1:0] eq;
    logic [NREQ-1:0]         hold;
    g = model_grant(vm);
    if (rnd_x) for (int i = 0; i < NREQ; i++) bus.req_x[i] = NST'($urandom);
    bus.req_valid = vm;
    salt = $urandom;
    xg = bus.req_x[g];
    #1;
    chk("req_ready_grant", 64'(bus.req_ready), 64'(onehot(g)));
    @(posedge clk);
    #1;
    if (chk_gap) chk("grant_gap", 64'(cyc - last_acc), 64'(SET + 2 + last_bp));
    last_acc = cyc;
    last_bp = bp;
    rr = (g + 1) % NREQ;
    hold = keep ? vm : '0;
    bus.req_valid = pulse ? (hold | onehot((g + 2) % NREQ)) : hold;
    #1;
    chk("ff_x_load", 64'(ff_x), 64'(xg));
    chk("req_ready_run", 64'(bus.req_ready), 64'h0);
    eq = use_fixed ? fixed_q : ffm(xg, salt);
    for (int c = 1; c < SET; c++) begin
      @(posedge clk);
      #1;
      bus.req_valid = hold;
      chk("rsp_valid_early", 64'(bus.rsp_valid), 64'h0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = hold;
    chk("rsp_valid_cap", 64'(bus.rsp_valid), 64'h1);
    chk("rsp_id", 64'(bus.rsp_id), 64'(g));
    chk("rsp_q", 64'(bus.rsp_q), 64'(eq));
    chk("ff_x_hold", 64'(ff_x), 64'(xg));
`ifdef FF_SCHED_ARGMAX_EN
    chk("rsp_action", 64'(bus.rsp_action), 64'(ref_argmax(eq)));
`endif
    bus.rsp_ready = (bp == 0);
    for (int b = 0; b < bp; b++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("bp_id", 64'(bus.rsp_id), 64'(g));
      chk("bp_q", 64'(bus.rsp_q), 64'(eq));
      chk("bp_req_ready", 64'(bus.req_ready), 64'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_valid_done", 64'(bus.rsp_valid), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_ff_x", 64'(ff_x), 64'h0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'h0);
    chk("rst_rsp_q", 64'(bus.rsp_q), 64'h0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester 2 with x=101.
    for (int i = 0; i < NREQ; i++) bus.req_x[i] = NST'($urandom);
    bus.req_x[2] = 3'b101;
    run_job(4'b0100, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // All valid: rotating grants spaced SETTLE+2 apart.
    for (int i = 0; i < NREQ; i++) bus.req_x[i] = NST'($urandom);
    run_job(4'b1111, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) run_job(4'b1111, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure for 5 cycles, then the next grant follows the handshake directly.
    run_job(4'b1111, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    run_job(4'b1111, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.req_valid = '0;
    @(posedge clk);
    #1;

    // Pulse from another requester while busy leaves the rotation alone.
    run_job(4'b0001, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_job(4'b1010, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_job(4'b1011, 1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset with cnt=1: job dropped, pointer back to 0.
    bus.req_valid = 4'b0010;
    #1;
    chk("abort_grant", 64'(bus.req_ready), 64'(onehot(model_grant(4'b0010))));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    @(posedge clk);
    #1;
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("abort_ff_x", 64'(ff_x), 64'h0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'h0);
    rr = 0;
    rst_n = 1'b1;
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("abort_no_rsp", 64'(bus.rsp_valid), 64'h0);
    end
    run_job(4'b1111, 0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef FF_SCHED_ARGMAX_EN
    use_fixed = 1'b1;
    fixed_q = {16'h0000, 16'h0080, 16'h0080, 16'h8100};
    run_job(4'b0001, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    fixed_q = {16'h0000, 16'h0000, 16'h0000, 16'h8000};
    run_job(4'b0010, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    use_fixed = 1'b0;
`endif

    // Randomized jobs.
    for (int n = 0; n < 20; n++)
      run_job(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0, 1'b1,
              1'($urandom_range(0, 1)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
